// File: rtl/loading_bar_ctrl_v2.sv
// AXI4-Lite LED progress bar (direct / ramp / scan, optional done-blink); reg write lands on the
// awready edge, read data 1 cycle after arready, LEDs registered; bvalid/rvalid stall new handshakes.
module loading_bar_ctrl_v2 #(
  parameter int N_LEDS             = 8,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int DIV_WIDTH          = 24,
  parameter int DIV_RESET          = 1_000_000
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [N_LEDS-1:0]               leds
);
  localparam int LW = $clog2(N_LEDS + 1);
  localparam int PW = $clog2(N_LEDS);
  localparam logic [LW-1:0] NL   = LW'(N_LEDS);
  localparam logic [31:0]   NL32 = 32'(N_LEDS);

  logic                 r_awready, r_bvalid, r_arready, r_rvalid;
  logic [31:0]          r_rdata;
  logic                 r_en, r_blink;
  logic [1:0]           r_mode;
  logic [LW-1:0]        r_target, r_cur;
  logic [DIV_WIDTH-1:0] r_div, r_cnt;
  logic                 r_phase, r_dir_dn;
  logic [PW-1:0]        r_pos;
  logic [N_LEDS-1:0]    r_leds;

  logic                 w_wr_en, w_div_wr, w_tick, w_done, w_busy, w_unused;
  logic [1:0]           w_mode;
  logic [31:0]          w_ctrl_rd, w_tgt_rd, w_div_rd, w_stat_rd;
  logic [31:0]          w_wr_old, w_wr_new, w_rd_mux;
  logic [N_LEDS-1:0]    w_therm, w_scan, w_leds_nxt;

  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

  assign s00_axi_awready = r_awready;
  assign s00_axi_wready  = r_awready;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = r_arready;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = 2'b00;
  assign leds            = r_leds;

  assign w_mode = (r_mode == 2'd3) ? 2'd0 : r_mode;
  assign w_done = (r_cur == NL);
  assign w_busy = (r_cur != r_target);
  assign w_tick = r_en && (r_cnt == r_div);

  assign w_ctrl_rd = {28'd0, r_blink, r_mode, r_en};
  assign w_tgt_rd  = {{(32 - LW){1'b0}}, r_target};
  assign w_div_rd  = {{(32 - DIV_WIDTH){1'b0}}, r_div};
  assign w_stat_rd = {15'd0, r_phase, 6'd0, w_done, w_busy, {(8 - LW){1'b0}}, r_cur};

  assign w_wr_en  = r_awready && s00_axi_awvalid && s00_axi_wvalid;
  assign w_div_wr = w_wr_en && (s00_axi_awaddr[3:2] == 2'd2);

  always_comb begin
    w_wr_old = 32'd0;
    case (s00_axi_awaddr[3:2])
      2'd0:    w_wr_old = w_ctrl_rd;
      2'd1:    w_wr_old = w_tgt_rd;
      2'd2:    w_wr_old = w_div_rd;
      default: w_wr_old = 32'd0;
    endcase
    // Unstrobed bytes keep their current contents
    w_wr_new = w_wr_old;
    for (int b = 0; b < 4; b++)
      if (s00_axi_wstrb[b]) w_wr_new[8*b +: 8] = s00_axi_wdata[8*b +: 8];
  end

  always_comb begin
    w_rd_mux = 32'd0;
    case (s00_axi_araddr[3:2])
      2'd0:    w_rd_mux = w_ctrl_rd;
      2'd1:    w_rd_mux = w_tgt_rd;
      2'd2:    w_rd_mux = w_div_rd;
      default: w_rd_mux = w_stat_rd;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      if (r_awready)
        r_awready <= 1'b0;
      else if (s00_axi_awvalid && s00_axi_wvalid && !r_bvalid)
        r_awready <= 1'b1;
      if (w_wr_en)
        r_bvalid <= 1'b1;
      else if (s00_axi_bready)
        r_bvalid <= 1'b0;

      if (r_arready)
        r_arready <= 1'b0;
      else if (s00_axi_arvalid && !r_rvalid)
        r_arready <= 1'b1;
      if (r_arready && s00_axi_arvalid) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_mux;
      end else if (s00_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_en     <= 1'b0;
      r_mode   <= 2'd0;
      r_blink  <= 1'b0;
      r_target <= '0;
      r_div    <= DIV_WIDTH'(DIV_RESET);
    end else if (w_wr_en) begin
      case (s00_axi_awaddr[3:2])
        2'd0:    {r_blink, r_mode, r_en} <= w_wr_new[3:0];
        2'd1:    r_target <= (w_wr_new > NL32) ? NL : w_wr_new[LW-1:0];
        2'd2:    r_div <= w_wr_new[DIV_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N_LEDS; i++) w_therm[i] = (i < int'(r_cur));
    w_scan = {{(N_LEDS - 1){1'b0}}, 1'b1} << r_pos;
    w_leds_nxt = '0;
    if (r_en) begin
      if (w_done && r_blink)
        w_leds_nxt = r_phase ? '0 : '1;
      else if (w_mode == 2'd2)
        w_leds_nxt = w_scan;
      else
        w_leds_nxt = w_therm;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_cnt    <= '0;
      r_cur    <= '0;
      r_phase  <= 1'b0;
      r_pos    <= '0;
      r_dir_dn <= 1'b0;
      r_leds   <= '0;
    end else begin
      r_leds <= w_leds_nxt;
      if (!r_en || w_div_wr || w_tick)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + DIV_WIDTH'(1);

      if (!r_en) begin
        r_pos    <= '0;
        r_dir_dn <= 1'b0;
      end else begin
        // Ramp holds cur between ticks, so a mode switch never makes it jump
        if (w_mode == 2'd1) begin
          if (w_tick && (r_cur < r_target))
            r_cur <= r_cur + LW'(1);
          else if (w_tick && (r_cur > r_target))
            r_cur <= r_cur - LW'(1);
        end else begin
          r_cur <= r_target;
        end

        if ((w_mode == 2'd2) && w_tick) begin
          if (!r_dir_dn) begin
            if (r_pos == PW'(N_LEDS - 1)) begin
              r_pos    <= PW'(N_LEDS - 2);
              r_dir_dn <= 1'b1;
            end else begin
              r_pos <= r_pos + PW'(1);
            end
          end else begin
            if (r_pos == '0) begin
              r_pos    <= PW'(1);
              r_dir_dn <= 1'b0;
            end else begin
              r_pos <= r_pos - PW'(1);
            end
          end
        end

        if (w_done && r_blink) begin
          if (w_tick) r_phase <= !r_phase;
        end else begin
          r_phase <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_loading_bar_ctrl_v2.sv
// Directed bench for loading_bar_ctrl_v2 (N_LEDS=8): register access, display modes, stalls, reset.
module tb_loading_bar_ctrl_v2;
  logic        clk, rst_n;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [7:0]  leds;

  int checks = 0;
  int errors = 0;
  int aw_hs  = 0;
  int ar_hs  = 0;

  loading_bar_ctrl_v2 #(.N_LEDS(8)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .leds(leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (awvalid && awready) aw_hs++;
    if (arvalid && arready) ar_hs++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Entered and left at 1ns after a rising edge
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("wr_timeout", 32'd1, 32'd0);
    chk("wready_with_awready", 32'(wready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid", 32'(bvalid), 32'd1);
    chk("bresp", 32'(bresp), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("rd_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rvalid", 32'(rvalid), 32'd1);
    chk("rresp", 32'(rresp), 32'd0);
    d = rdata;
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;
  logic [7:0]  s [0:39];
  logic [7:0]  vals [0:3];
  int          cyc [0:3];
  int          nchg, k, aw0, ar0;
  logic [7:0]  prev;

  initial begin
    rst_n = 1'b0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; wdata = '0; wstrb = '0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    wait_cyc(1);
    axi_read(4'hC, rd); chk("rst_status", rd, 32'd0);
    axi_read(4'h8, rd); chk("rst_divider", rd, 32'd1_000_000);

    // Register write/readback; STATUS write is dropped
    axi_write(4'h0, 32'd1, 4'hF);
    axi_write(4'h4, 32'd2, 4'hF);
    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'hC, 32'd4, 4'hF);
    axi_read(4'h0, rd); chk("rb_ctrl", rd, 32'd1);
    axi_read(4'h4, rd); chk("rb_target", rd, 32'd2);
    axi_read(4'h8, rd); chk("rb_divider", rd, 32'd3);
    axi_read(4'hC, rd); chk("rb_status", rd, 32'd2);
    axi_write(4'h4, 32'd7, 4'h0);
    axi_read(4'h4, rd); chk("strb_none", rd, 32'd2);
    axi_write(4'h8, 32'h00AABBCC, 4'b0010);
    axi_read(4'h8, rd); chk("strb_byte1", rd, 32'h0000BB03);

    // Direct mode and saturation
    axi_write(4'h4, 32'd5, 4'hF);
    wait_cyc(2);
    chk("direct_5", 32'(leds), 32'h1F);
    axi_write(4'h4, 32'd99, 4'hF);
    axi_read(4'h4, rd); chk("sat_target", rd, 32'd8);
    wait_cyc(2);
    chk("direct_sat_leds", 32'(leds), 32'hFF);
    axi_read(4'hC, rd); chk("status_done", rd, 32'h208);

    // Ramp mode
    axi_write(4'h4, 32'd0, 4'hF);
    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'h0, 32'd3, 4'hF);
    wait_cyc(2);
    chk("ramp_start", 32'(leds), 32'd0);
    axi_write(4'h4, 32'd3, 4'hF);
    prev = leds; nchg = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (leds !== prev) begin
        if (nchg < 4) begin vals[nchg] = leds; cyc[nchg] = c; end
        nchg++;
        prev = leds;
      end
    end
    chk("ramp_nchg", 32'(nchg), 32'd3);
    chk("ramp_v0", 32'(vals[0]), 32'h01);
    chk("ramp_v1", 32'(vals[1]), 32'h03);
    chk("ramp_v2", 32'(vals[2]), 32'h07);
    chk("ramp_gap01", 32'(cyc[1] - cyc[0]), 32'd4);
    chk("ramp_gap12", 32'(cyc[2] - cyc[1]), 32'd4);
    axi_read(4'hC, rd); chk("ramp_idle_status", rd, 32'd3);
    axi_write(4'h4, 32'd0, 4'hF);
    axi_read(4'hC, rd); chk("ramp_busy", 32'(rd[8]), 32'd1);
    wait_cyc(20);
    chk("ramp_down_leds", 32'(leds), 32'd0);

    // Scan mode, tick every cycle
    axi_write(4'h8, 32'd0, 4'hF);
    axi_write(4'h0, 32'd5, 4'hF);
    for (int c = 0; c < 40; c++) begin s[c] = leds; @(posedge clk); #1; end
    k = -1;
    for (int c = 0; c < 20; c++)
      if (k < 0 && s[c] == 8'h01 && s[c+1] == 8'h02) k = c;
    chk("scan_found", 32'(k >= 0), 32'd1);
    if (k >= 0)
      for (int j = 0; j <= 14; j++)
        chk("scan_seq", 32'(s[k+j]), 32'd1 << ((j <= 7) ? j : 14 - j));

    // Blink on done
    axi_write(4'h4, 32'd8, 4'hF);
    axi_write(4'h8, 32'd1, 4'hF);
    axi_write(4'h0, 32'd9, 4'hF);
    for (int c = 0; c < 24; c++) begin s[c] = leds; @(posedge clk); #1; end
    k = -1;
    for (int c = 1; c < 12; c++)
      if (k < 0 && s[c] == 8'hFF && s[c-1] == 8'h00) k = c;
    chk("blink_found", 32'(k >= 0), 32'd1);
    if (k >= 0)
      for (int j = 0; j < 8; j++)
        chk("blink_seq", 32'(s[k+j]), (((j / 2) % 2) == 0) ? 32'hFF : 32'h00);
    axi_write(4'h0, 32'd1, 4'hF);
    wait_cyc(3);
    chk("steady_ff_a", 32'(leds), 32'hFF);
    wait_cyc(3);
    chk("steady_ff_b", 32'(leds), 32'hFF);

    // Stalled responses must not allow a second handshake
    aw0 = aw_hs;
    bready = 1'b0;
    awaddr = 4'h4; wdata = 32'd3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    wait_cyc(12);
    chk("stall_aw_hs", 32'(aw_hs - aw0), 32'd1);
    chk("stall_bvalid", 32'(bvalid), 32'd1);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    wait_cyc(1);
    chk("stall_bvalid_clr", 32'(bvalid), 32'd0);
    ar0 = ar_hs;
    rready = 1'b0;
    araddr = 4'h4; arvalid = 1'b1;
    wait_cyc(12);
    chk("stall_ar_hs", 32'(ar_hs - ar0), 32'd1);
    chk("stall_rvalid", 32'(rvalid), 32'd1);
    chk("stall_rdata", rdata, 32'd3);
    arvalid = 1'b0; araddr = 4'h0;
    wait_cyc(1);
    chk("stall_rdata_hold", rdata, 32'd3);
    rready = 1'b1;
    wait_cyc(1);
    chk("stall_rvalid_clr", 32'(rvalid), 32'd0);

    // Reset during a write handshake
    awaddr = 4'h0; wdata = 32'hF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    k = 0;
    while (!awready && k < 50) begin @(posedge clk); #1; k++; end
    chk("rstw_awready_seen", 32'(awready), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_awready", 32'(awready), 32'd0);
    chk("rstw_bvalid", 32'(bvalid), 32'd0);
    chk("rstw_leds", 32'(leds), 32'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(1);
    axi_read(4'h0, rd); chk("rstw_ctrl", rd, 32'd0);
    axi_read(4'h4, rd); chk("rstw_target", rd, 32'd0);
    axi_read(4'h8, rd); chk("rstw_divider", rd, 32'd1_000_000);
    axi_read(4'hC, rd); chk("rstw_status", rd, 32'd0);
    chk("rstw_leds_after", 32'(leds), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
